// File: rtl/pacote_controle.sv
// Shared opcodes, state encoding and pc_origem codes for the multi-cycle controller.
// Opcode classification lives here so decode and execute agree on one definition.
package pacote_controle;

  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1101;
  localparam logic [3:0] OP_JUMP  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] OP_BEQ   = 2'b00;
  localparam logic [1:0] OP_INDEF = 2'b01;
  localparam logic [1:0] OP_ALU   = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BEQ = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] SEL_REG_BEQ = 2'b10;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    DECOD   = 3'd2,
    EXEC    = 3'd3,
    MEM     = 3'd4,
    ESCRITA = 3'd5,
    PARADO  = 3'd6,
    ERRO    = 3'd7
  } estado_t;

  typedef enum logic [2:0] {
    CL_BEQ,
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_JUMP,
    CL_HALT,
    CL_INDEF
  } classe_t;

  function automatic classe_t classifica(input logic [3:0] op);
    classe_t c;
    case (op)
      OP_LOAD:  c = CL_LOAD;
      OP_STORE: c = CL_STORE;
      OP_JUMP:  c = CL_JUMP;
      OP_HALT:  c = CL_HALT;
      default: begin
        case (op[3:2])
          OP_BEQ:  c = CL_BEQ;
          OP_ALU:  c = CL_ALU;
          default: c = CL_INDEF;
        endcase
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Wait-state counter for the data-memory handshake; flags when the last
// allowed wait cycle has been reached.
module contador_espera #(
  parameter int CNT_W  = 4,
  parameter int LIMITE = 14
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  output logic no_limite
);

  logic [CNT_W-1:0] contagem;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (habilita) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign no_limite = (contagem == CNT_W'(LIMITE));

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle controller: BUSCA/DECOD/EXEC/MEM/ESCRITA sequencing for the 8-bit
// datapath, with a bounded req/ack handshake towards the data memory.
module sequenciador_multiciclo
  import pacote_controle::*;
#(
  parameter int TIMEOUT_CICLOS = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instrucao,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       ir_carrega,
  output logic       pc_escreve,
  output logic [1:0] pc_origem,
  output logic       reg_escreve,
  output logic       mem_reg,
  output logic       origem,
  output logic       op_alu,
  output logic [1:0] decide_reg_salto,
  output logic       mem_req,
  output logic       le_mem,
  output logic       escreve_mem,
  output logic       parado,
  output logic       erro,
  output logic [2:0] estado
);

  estado_t    estado_q, estado_prox;
  logic [3:0] opcode_q;
  classe_t    classe;
  logic       espera_limpa, espera_habilita, espera_limite;
  logic       operando_unused;

  assign classe          = classifica(opcode_q);
  assign estado          = estado_q;
  assign operando_unused = ^instrucao[3:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      opcode_q <= '0;
    end else begin
      estado_q <= estado_prox;
      if (estado_q == DECOD) begin
        opcode_q <= instrucao[7:4];
      end
    end
  end

  // Counter runs only while stalled in MEM and is cleared whenever MEM is not next.
  assign espera_limpa    = (estado_prox != MEM);
  assign espera_habilita = (estado_q == MEM) && !mem_ack;

  contador_espera #(
    .CNT_W  (CNT_W),
    .LIMITE (TIMEOUT_CICLOS - 1)
  ) u_contador_espera (
    .clock     (clock),
    .reset     (reset),
    .limpa     (espera_limpa),
    .habilita  (espera_habilita),
    .no_limite (espera_limite)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    estado_prox      = estado_q;
    ir_carrega       = 1'b0;
    pc_escreve       = 1'b0;
    pc_origem        = PC_INC;
    reg_escreve      = 1'b0;
    mem_reg          = 1'b0;
    origem           = 1'b0;
    op_alu           = 1'b0;
    decide_reg_salto = 2'b00;
    mem_req          = 1'b0;
    le_mem           = 1'b0;
    escreve_mem      = 1'b0;
    parado           = 1'b0;
    erro             = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (start) estado_prox = BUSCA;
      end

      BUSCA: begin
        ir_carrega  = 1'b1;
        estado_prox = DECOD;
      end

      DECOD: begin
        case (classifica(instrucao[7:4]))
          CL_HALT:  estado_prox = PARADO;
          CL_INDEF: estado_prox = ERRO;
          default:  estado_prox = EXEC;
        endcase
      end

      EXEC: begin
        case (classe)
          CL_ALU: begin
            origem      = 1'b1;
            op_alu      = 1'b1;
            estado_prox = ESCRITA;
          end
          CL_BEQ: begin
            decide_reg_salto = SEL_REG_BEQ;
            pc_escreve       = 1'b1;
            pc_origem        = zero ? PC_BEQ : PC_INC;
            estado_prox      = BUSCA;
          end
          CL_JUMP: begin
            pc_escreve  = 1'b1;
            pc_origem   = PC_JMP;
            estado_prox = BUSCA;
          end
          CL_LOAD, CL_STORE: begin
            origem      = 1'b1;
            estado_prox = MEM;
          end
          default: estado_prox = ERRO;
        endcase
      end

      MEM: begin
        mem_req     = 1'b1;
        origem      = 1'b1;
        le_mem      = (classe == CL_LOAD);
        escreve_mem = (classe == CL_STORE);
        mem_reg     = (classe == CL_LOAD);
        // Store retires on the ack cycle itself, so the PC advances there.
        pc_escreve  = (classe == CL_STORE) && mem_ack;
        if (mem_ack) begin
          estado_prox = (classe == CL_LOAD) ? ESCRITA : BUSCA;
        end else if (espera_limite) begin
          estado_prox = ERRO;
        end
      end

      ESCRITA: begin
        reg_escreve = 1'b1;
        pc_escreve  = 1'b1;
        pc_origem   = PC_INC;
        mem_reg     = (classe == CL_LOAD);
        origem      = (classe == CL_ALU);
        op_alu      = (classe == CL_ALU);
        estado_prox = BUSCA;
      end

      PARADO: begin
        parado = 1'b1;
        if (start) estado_prox = BUSCA;
      end

      ERRO: begin
        erro = 1'b1;
      end

      default: estado_prox = ERRO;
    endcase
  end

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Bench for sequenciador_multiciclo: per-cycle vector tables built from an
// instruction-level model, directed corner cases and randomized programs.
module tb_sequenciador_multiciclo;

  localparam logic [2:0] ST_OCI = 3'd0, ST_BUS = 3'd1, ST_DEC = 3'd2, ST_EXE = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_ESC = 3'd5, ST_PAR = 3'd6, ST_ERR = 3'd7;

  typedef struct packed {
    logic       ir;
    logic       pcw;
    logic [1:0] pco;
    logic       rw;
    logic       mr;
    logic       org;
    logic       alu;
    logic [1:0] drs;
    logic       mreq;
    logic       le;
    logic       we;
    logic       par;
    logic       err;
  } outs_t;

  typedef struct {
    logic       start;
    logic       ack;
    logic       zero;
    logic [7:0] ins;
    logic [2:0] st;
    outs_t      o;
    outs_t      care;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] instrucao = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       ir_carrega, pc_escreve, reg_escreve, mem_reg, origem, op_alu;
  logic [1:0] pc_origem, decide_reg_salto;
  logic       mem_req, le_mem, escreve_mem, parado, erro;
  logic [2:0] estado;
  outs_t      obs;

  vec_t  vq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    noisy = 1'b0;
  string tag = "";

  sequenciador_multiciclo dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .instrucao        (instrucao),
    .zero             (zero),
    .mem_ack          (mem_ack),
    .ir_carrega       (ir_carrega),
    .pc_escreve       (pc_escreve),
    .pc_origem        (pc_origem),
    .reg_escreve      (reg_escreve),
    .mem_reg          (mem_reg),
    .origem           (origem),
    .op_alu           (op_alu),
    .decide_reg_salto (decide_reg_salto),
    .mem_req          (mem_req),
    .le_mem           (le_mem),
    .escreve_mem      (escreve_mem),
    .parado           (parado),
    .erro             (erro),
    .estado           (estado)
  );

  always #5 clock = ~clock;

  assign obs = {ir_carrega, pc_escreve, pc_origem, reg_escreve, mem_reg, origem, op_alu,
                decide_reg_salto, mem_req, le_mem, escreve_mem, parado, erro};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic rnd();
    return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void push(input logic [2:0] st, input outs_t o, input outs_t care,
                               input logic s, input logic a, input logic z, input logic [7:0] ins);
    vec_t v;
    v.start = s; v.ack = a; v.zero = z; v.ins = ins;
    v.st = st; v.o = o; v.care = care;
    vq.push_back(v);
  endfunction

  function automatic void push_idle_start(input logic [7:0] ins);
    push(ST_OCI, '0, '1, 1'b0, rnd(), rnd(), ins);
    push(ST_OCI, '0, '1, 1'b1, rnd(), rnd(), ins);
  endfunction

  function automatic void push_busca(input logic [7:0] ins);
    outs_t o;
    o = '0; o.ir = 1'b1;
    push(ST_BUS, o, '1, rnd(), rnd(), rnd(), ins);
  endfunction

  // Instruction-level model: w = cycle of MEM on which ack arrives, w < 0 = never.
  function automatic void gen_instr(input logic [7:0] ins, input logic z, input int w);
    outs_t o, c;
    logic [3:0] op;
    int n;
    op = ins[7:4];
    push_busca(ins);
    push(ST_DEC, '0, '1, rnd(), rnd(), rnd(), ins);
    if (op == 4'hF) begin
      o = '0; o.par = 1'b1;
      push(ST_PAR, o, '1, 1'b0, rnd(), rnd(), ins);
      push(ST_PAR, o, '1, 1'b1, rnd(), rnd(), ins);
      return;
    end
    if (op[3:2] == 2'b01) begin
      o = '0; o.err = 1'b1;
      for (int k = 0; k < 3; k++) push(ST_ERR, o, '1, 1'b1, 1'b1, rnd(), ins);
      return;
    end
    c = '1; c.org = 1'b0; c.alu = 1'b0;
    o = '0;
    if (op[3:2] == 2'b10) begin
      o.org = 1'b1; o.alu = 1'b1;
      push(ST_EXE, o, '1, rnd(), rnd(), rnd(), ins);
      o = '0; o.rw = 1'b1; o.pcw = 1'b1;
      push(ST_ESC, o, c, rnd(), rnd(), rnd(), ins);
    end else if (op[3:2] == 2'b00) begin
      o.drs = 2'b10; o.pcw = 1'b1; o.pco = z ? 2'b01 : 2'b00;
      c.alu = 1'b1;
      push(ST_EXE, o, c, rnd(), rnd(), z, ins);
    end else if (op == 4'hE) begin
      o.pcw = 1'b1; o.pco = 2'b10;
      push(ST_EXE, o, c, rnd(), rnd(), rnd(), ins);
    end else begin
      push(ST_EXE, o, c, rnd(), rnd(), rnd(), ins);
      n = (w < 0) ? 15 : w + 1;
      c.mr = 1'b0;
      for (int j = 0; j < n; j++) begin
        o = '0; o.mreq = 1'b1;
        o.le = (op == 4'hC);
        o.we = (op == 4'hD);
        o.pcw = (op == 4'hD) && (j == w);
        push(ST_MEM, o, c, rnd(), (j == w), rnd(), ins);
      end
      if (w < 0) begin
        o = '0; o.err = 1'b1;
        for (int k = 0; k < 3; k++) push(ST_ERR, o, '1, 1'b1, rnd(), rnd(), ins);
      end else if (op == 4'hC) begin
        o = '0; o.rw = 1'b1; o.pcw = 1'b1; o.mr = 1'b1;
        c = '1; c.org = 1'b0; c.alu = 1'b0;
        push(ST_ESC, o, c, rnd(), rnd(), rnd(), ins);
      end
    end
  endfunction

  task automatic run_trace();
    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; mem_ack = vq[i].ack; zero = vq[i].zero; instrucao = vq[i].ins;
      #1;
      n_checks++;
      if (estado !== vq[i].st || (obs & vq[i].care) !== (vq[i].o & vq[i].care)) begin
        n_errors++;
        $display("FAIL %s[%0d]: estado=%0d outs=%b, expected estado=%0d outs=%b care=%b",
                 tag, i, estado, obs, vq[i].st, vq[i].o, vq[i].care);
      end
      @(posedge clock);
      #1;
    end
    vq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    #1;
    check({tag, "_reset"}, {14'd0, estado, obs}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    logic [7:0] ins;
    int w;

    tag = "t1";
    do_reset();
    push_idle_start(8'b11001000);
    gen_instr(8'b11001000, 1'b0, 10);
    vq = vq[0:5];
    run_trace();
    check("t1_mem_req_before_reset", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("t1_async_drop", {14'd0, estado, obs}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check("t1_idle_after_reset", {14'd0, estado, obs}, 32'd0);
    end

    tag = "t2_alu";
    do_reset();
    push_idle_start(8'b10011000);
    gen_instr(8'b10011000, 1'b0, 0);
    push_busca(8'b10011000);
    run_trace();

    tag = "t3_beq";
    do_reset();
    push_idle_start(8'b00101000);
    gen_instr(8'b00101000, 1'b1, 0);
    gen_instr(8'b00101000, 1'b0, 0);
    push_busca(8'b00101000);
    run_trace();

    tag = "t4_load_w3";
    do_reset();
    push_idle_start(8'b11001000);
    gen_instr(8'b11001000, 1'b0, 3);
    push_busca(8'b11001000);
    run_trace();

    tag = "t5_store_timeout";
    do_reset();
    push_idle_start(8'b11010001);
    gen_instr(8'b11010001, 1'b0, -1);
    run_trace();
    do_reset();
    check("t5_cleared", {29'd0, estado}, 32'd0);

    tag = "t6_halt_undef";
    do_reset();
    push_idle_start(8'b11111000);
    gen_instr(8'b11111000, 1'b0, 0);
    gen_instr(8'b01000000, 1'b0, 0);
    run_trace();

    tag = "bounds";
    do_reset();
    push_idle_start(8'b11000000);
    gen_instr(8'b11000000, 1'b0, 0);
    gen_instr(8'b11000011, 1'b0, 14);
    gen_instr(8'b11000101, 1'b0, 14);
    gen_instr(8'b11010010, 1'b0, 0);
    gen_instr(8'b11010110, 1'b1, 14);
    gen_instr(8'b11100111, 1'b0, 0);
    gen_instr(8'b10110101, 1'b1, 0);
    push_busca(8'b10110101);
    run_trace();

    tag = "random";
    noisy = 1'b1;
    do_reset();
    push_idle_start(8'h00);
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0:       op = {2'b00, 2'($urandom_range(0, 3))};
        1:       op = {2'b10, 2'($urandom_range(0, 3))};
        2:       op = 4'hC;
        3:       op = 4'hD;
        4:       op = 4'hE;
        default: op = 4'hF;
      endcase
      ins = {op, 4'($urandom_range(0, 15))};
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
      gen_instr(ins, 1'($urandom_range(0, 1)), w);
    end
    push_busca(8'h00);
    run_trace();
    noisy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
